div: RTL and testbench
======================

Name: div

Overview:
- Multi-cycle 32-bit integer divider serving the execute stage's DIV/DIVU operations.
- EX is the initiator: it raises start_i with the operands and holds it until ready_o.
- This block returns {remainder, quotient}; EX routes these to hi_o/lo_o and asserts whilo_o.
- Radix-2 restoring division, one quotient bit per cycle; the pipeline stalls while busy.

Parameters:
- DATA_W, 32, operand width; only 32 is supported. The result is 2*DATA_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU. Sampled on the accept edge only.
- opdata1_i  in  32  dividend. Sampled on the accept edge only.
- opdata2_i  in  32  divisor. Sampled on the accept edge only.
- start_i  in  1  request. Held high by EX until ready_o has been seen.
- annul_i  in  1  cancel. Asserted on branch flush or exception.
- result_o  out  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}. Registered.
- ready_o  out  1  result valid. Registered.

Behaviour:
- States: FREE, BYZERO, ON, END. State, cnt[5:0], the working registers and both outputs are registers.
- Reset:
  - When rst=1 at an edge: state=FREE, cnt=0, result_o=0, ready_o=0.
  - Reset has priority over everything, including mid-operation. Any in-flight division is discarded.
- FREE:
  - Accept edge: start_i=1 and annul_i=0.
  - If opdata2_i==0 -> BYZERO.
  - Otherwise latch operands -> ON, cnt=0. Magnitudes are taken here: in signed mode negative operands are two's-complemented; in unsigned mode operands are used raw.
  - Latch the sign flags: quotient-negate = signs differ (signed only); remainder-negate = dividend negative (signed only).
  - With no accept, stay in FREE; result_o=0, ready_o=0.
- ON:
  - Each edge performs one iteration: partial remainder shifted left with the next dividend bit; trial-subtract the divisor; if non-negative keep the difference and set the quotient bit to 1, else restore and set it to 0. Then cnt+1.
  - On the 32nd iteration edge (cnt 31 -> 32): go to END and load sign-corrected result_o; set ready_o=1 on the same edge.
  - Latency: ready_o is first high 32 cycles after the accept edge.
- BYZERO: next edge -> END with result_o=0, ready_o=1. Latency is 1 cycle after accept. No exception is raised (MIPS leaves the result unpredictable; we define it as 0).
- END:
  - ready_o and result_o hold while start_i=1.
  - On the first edge with start_i=0 -> FREE, ready_o=0, result_o=0.
  - A new operation needs start_i to drop for at least one cycle. Back-to-back requests therefore cost one idle cycle.
- annul_i:
  - In ON or BYZERO, annul_i=1 at an edge -> FREE; ready_o stays 0 and no result is produced.
  - In END, annul_i=1 -> FREE, outputs cleared.
  - annul_i outranks start_i.
- Sign and width rules:
  - Quotient truncates toward zero.
  - Remainder sign follows the dividend.
  - Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000 (wraps), remainder 0, no trap.
- Operand changes on opdata*_i after the accept edge are ignored.

Decomposition:
- Shared package/defines: state encodings DivFree=2'b00, DivByZero=2'b01, DivOn=2'b10, DivEnd=2'b11. Also DivResultReady/NotReady, DivStart/Stop, and DoubleRegBus[63:0].
- EX gets new ports div_opdata1_o, div_opdata2_o, div_start_o, signed_div_o, div_result_i, div_ready_i, plus a stallreq.
- Single module; no sub-module is needed. The 33-bit trial subtractor is inline.

Test Plan:
- Unsigned 100/7:
  - Stimulus: signed_div_i=0, hold start_i.
  - Response: ready_o first high exactly 32 cycles after the accept edge; result_o=0x00000002_0000000E.
  - Drop start_i: next cycle ready_o=0 and result_o=0.
- Signed -7/2:
  - Stimulus: 0xFFFFFFF9 / 0x00000002.
  - Response: result_o=0xFFFFFFFF_FFFFFFFD (remainder -1, quotient -3). 7/-2 gives 0x00000001_FFFFFFFD.
- Divide by zero:
  - Stimulus: opdata2_i=0.
  - Response: ready_o high 1 cycle after accept, result_o=0. Holds while start_i=1.
- Edge operands:
  - Signed 0x80000000/0xFFFFFFFF -> 0x00000000_80000000.
  - Unsigned 0xFFFFFFFF/0x00000001 -> 0x00000000_FFFFFFFF.
  - Unsigned 5/9 -> 0x00000005_00000000.
- annul_i pulse at cycle 10 of ON -> state FREE next cycle; ready_o never rises. A fresh request of 100/7 afterwards still gives the correct result at +32.
- rst=1 asserted at cycle 20 of ON -> next cycle FREE with ready_o=0 and result_o=0; the held start_i is re-accepted after rst falls.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants and types for the multi-cycle integer divider.
// State encodings stay as plain 2-bit constants so existing code can still compare against them.
package div_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] DivFree   = 2'b00;
    localparam logic [1:0] DivByZero = 2'b01;
    localparam logic [1:0] DivOn     = 2'b10;
    localparam logic [1:0] DivEnd    = 2'b11;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    typedef logic [2*DATA_W-1:0] double_reg_bus_t;

    // Two's-complement magnitude of x when negation is requested.
    function automatic logic [DATA_W-1:0] cond_neg(input logic neg, input logic [DATA_W-1:0] x);
        return neg ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/div_if.sv
// Request/response bundle between the execute stage (master) and the divider (slave).
interface div_if;
    import div_pkg::*;

    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    double_reg_bus_t       result_o;
    logic                  ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );

endinterface

// File: rtl/div.sv
// Radix-2 restoring divider: one quotient bit per cycle, result {remainder, quotient}.
// Signed division runs on magnitudes; signs are re-applied when the last bit is produced.
module div
    import div_pkg::*;
#(
    parameter int DATA_W_P = DATA_W   // only 32 is supported
) (
    input logic  clk,
    input logic  rst,
    div_if.slave bus
);

    logic [1:0]        state;
    logic [5:0]        cnt;
    logic [DATA_W-1:0] dvd;     // dividend bits shift out the top, quotient bits shift in the bottom
    logic [DATA_W-1:0] dsr;
    logic [DATA_W-1:0] rem;
    logic              neg_q;
    logic              neg_r;

    logic              accept;
    logic [DATA_W-1:0] mag1;
    logic [DATA_W-1:0] mag2;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   diff;
    logic              q_bit;
    logic [DATA_W-1:0] rem_next;
    logic [DATA_W-1:0] quo_next;

    always_comb begin
        accept   = (bus.start_i == DivStart) && !bus.annul_i;
        mag1     = cond_neg(bus.signed_div_i && bus.opdata1_i[DATA_W-1], bus.opdata1_i);
        mag2     = cond_neg(bus.signed_div_i && bus.opdata2_i[DATA_W-1], bus.opdata2_i);

        // 33-bit trial subtract: a clear borrow bit means the divisor fits.
        shifted  = {rem, dvd[DATA_W-1]};
        diff     = shifted - {1'b0, dsr};
        q_bit    = ~diff[DATA_W];
        rem_next = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
        quo_next = {dvd[DATA_W-2:0], q_bit};
    end

    // NOTE: non-blocking assignments throughout so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= DivFree;
            cnt          <= '0;
            bus.result_o <= '0;
            bus.ready_o  <= DivResultNotReady;
        end else begin
            case (state)
                DivFree: begin
                    bus.result_o <= '0;
                    bus.ready_o  <= DivResultNotReady;
                    if (accept) begin
                        if (bus.opdata2_i == '0) begin
                            state <= DivByZero;
                        end else begin
                            state <= DivOn;
                            cnt   <= '0;
                            dvd   <= mag1;
                            dsr   <= mag2;
                            rem   <= '0;
                            neg_q <= bus.signed_div_i && (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]);
                            neg_r <= bus.signed_div_i && bus.opdata1_i[DATA_W-1];
                        end
                    end
                end

                DivByZero: begin
                    if (bus.annul_i) begin
                        state <= DivFree;
                    end else begin
                        state        <= DivEnd;
                        bus.result_o <= '0;
                        bus.ready_o  <= DivResultReady;
                    end
                end

                DivOn: begin
                    if (bus.annul_i) begin
                        state <= DivFree;
                    end else begin
                        dvd <= quo_next;
                        rem <= rem_next;
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'(DATA_W - 1)) begin
                            state        <= DivEnd;
                            bus.result_o <= {cond_neg(neg_r, rem_next), cond_neg(neg_q, quo_next)};
                            bus.ready_o  <= DivResultReady;
                        end
                    end
                end

                default: begin  // DivEnd: hold the result until EX drops start_i
                    if (bus.annul_i || bus.start_i == DivStop) begin
                        state        <= DivFree;
                        bus.result_o <= '0;
                        bus.ready_o  <= DivResultNotReady;
                    end
                end
            endcase
        end
    end

    // NOTE: the datapath registers (dvd, dsr, rem, sign flags) are left out of reset; they are
    // always loaded on the accept edge before anything reads them.

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: scoreboard of expected {remainder, quotient} and latency,
// checked against an independent 64-bit arithmetic model.
module tb_div;
    import div_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    div_if bus ();

    div #(.DATA_W_P(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] res;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Reference model using 64-bit host arithmetic (truncating division, remainder follows dividend).
    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb_, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb_ = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb_ = longint'({32'd0, b});
        end
        q = sa / sb_;
        r = sa % sb_;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic drive_raw(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
    endtask

    task automatic drive(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        drive_raw(sgn, a, b);
        sb.push_back('{tag, model(sgn, a, b), (b == 32'd0) ? 1 : 32});
    endtask

    // Called at a negedge with start_i already high; the next posedge is the accept edge.
    task automatic wait_result();
        exp_t e;
        int   n;
        e = sb.pop_front();
        n = 0;
        @(posedge clk);
        #1;
        bus.opdata1_i    = $urandom;   // must be ignored after accept
        bus.opdata2_i    = $urandom;
        bus.signed_div_i = ~bus.signed_div_i;
        while (n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus.ready_o) break;
        end
        check({e.tag, " latency"}, 64'(n), 64'(e.lat));
        check({e.tag, " result"}, bus.result_o, e.res);
        @(negedge clk);
        check({e.tag, " hold ready"}, 64'(bus.ready_o), 64'd1);
        check({e.tag, " hold result"}, bus.result_o, e.res);
        bus.start_i = 1'b0;
        @(negedge clk);
        check({e.tag, " clear ready"}, 64'(bus.ready_o), 64'd0);
        check({e.tag, " clear result"}, bus.result_o, 64'd0);
    endtask

    task automatic run(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        drive(tag, sgn, a, b);
        wait_result();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int highs;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;

        repeat (3) @(negedge clk);
        check("reset ready", 64'(bus.ready_o), 64'd0);
        check("reset result", bus.result_o, 64'd0);
        check("reset state", 64'(dut.state), 64'(DivFree));
        rst = 1'b0;
        @(negedge clk);

        run("udiv 100/7",      1'b0, 32'd100,        32'd7);
        run("sdiv -7/2",       1'b1, 32'hFFFF_FFF9,  32'd2);
        run("sdiv 7/-2",       1'b1, 32'd7,          32'hFFFF_FFFE);
        run("div by zero",     1'b1, 32'd1234,       32'd0);
        run("sdiv min/-1",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF);
        run("udiv max/1",      1'b0, 32'hFFFF_FFFF,  32'd1);
        run("udiv 5/9",        1'b0, 32'd5,          32'd9);
        run("udiv max/max",    1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
        run("sdiv -100/-7",    1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9);

        // Annul mid-operation: no result may appear, then a fresh request still works.
        drive_raw(1'b0, 32'd100, 32'd7);
        @(posedge clk);
        repeat (10) @(negedge clk);
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        @(negedge clk);
        check("annul state", 64'(dut.state), 64'(DivFree));
        check("annul ready", 64'(bus.ready_o), 64'd0);
        bus.annul_i = 1'b0;
        highs = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.ready_o) highs++;
        end
        check("annul no ready", 64'(highs), 64'd0);
        run("after annul 100/7", 1'b0, 32'd100, 32'd7);

        // Reset mid-operation with start held: discarded, then re-accepted once reset drops.
        drive_raw(1'b0, 32'd100, 32'd7);
        @(posedge clk);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid rst state", 64'(dut.state), 64'(DivFree));
        check("mid rst ready", 64'(bus.ready_o), 64'd0);
        check("mid rst result", bus.result_o, 64'd0);
        rst = 1'b0;
        sb.push_back('{"after rst 100/7", model(1'b0, 32'd100, 32'd7), 32});
        wait_result();

        for (int i = 0; i < 8; i++) begin
            logic        sgn;
            logic [31:0] a, b;
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = $urandom >> $urandom_range(0, 31);
            run($sformatf("rand%0d", i), sgn, a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
